instr_feeder: RTL and testbench

- Upstream instruction-issue stage for the `cpu` block.
- Buffers 16-bit instructions pushed by a host or loader in a small FIFO.
- Presents each instruction to the cpu through its `in`/`load`/`s` handshake and waits on `w` for completion.
- Captures `out` and the N/V/Z flags per instruction and reports them with a one-cycle `done` pulse, so the cpu runs instruction streams without bench-level sequencing.

---
 rtl/instr_feeder.sv | 178 +++++++++++++++++
 tb/tb_instr_feeder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Instruction feeder: buffers 16-bit instructions in a FIFO and issues each one to the cpu
// through the load/s handshake, then waits on w and reports result/flags with a done pulse.
`timescale 1ns/1ps

module instr_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] push_data,
  output logic        full,
  output logic        empty,
  output logic        ovf,
  output logic [15:0] cpu_in,
  output logic        cpu_load,
  output logic        cpu_s,
  input  logic        cpu_w,
  input  logic [15:0] cpu_out,
  input  logic        cpu_N,
  input  logic        cpu_V,
  input  logic        cpu_Z,
  output logic [15:0] result,
  output logic [2:0]  flags,
  output logic        done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_LEAVE,
    S_WAIT_DONE,
    S_CAPTURE,
    S_ERR
  } state_e;

  state_e         r_state;
  logic [15:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [TW-1:0]  r_tcnt;
  logic           r_load_ph;

  logic           w_push_ok;
  logic           w_pop;
  logic [CW-1:0]  w_count_nxt;
  logic [15:0]    w_head;
  logic           w_timeout;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_push_ok   = push && !full;
    w_pop       = (r_state == S_CAPTURE);
    w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);
    w_head      = r_mem[r_rd_ptr];
    w_timeout   = 1'b0;
    if (r_tcnt == TW'(TIMEOUT - 1)) begin
      if (r_state == S_WAIT_LEAVE && cpu_w)  w_timeout = 1'b1;
      if (r_state == S_WAIT_DONE  && !cpu_w) w_timeout = 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == CW'(DEPTH));
      empty   <= (w_count_nxt == '0);
      if (push && full) ovf <= 1'b1;
    end
  end

  // Outputs are set on the transition into a state so they line up with that state's cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_load_ph   <= 1'b0;
      cpu_in      <= '0;
      cpu_load    <= 1'b0;
      cpu_s       <= 1'b0;
      result      <= '0;
      flags       <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_timeout) begin
        r_state     <= S_ERR;
        timeout_err <= 1'b1;
        cpu_in      <= '0;
        cpu_load    <= 1'b0;
        cpu_s       <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!empty) begin
              cpu_in    <= w_head;
              cpu_load  <= 1'b1;
              busy      <= 1'b1;
              r_load_ph <= 1'b0;
              r_state   <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (r_load_ph) begin
              cpu_load <= 1'b0;
              cpu_s    <= 1'b1;
              r_state  <= S_START;
            end else begin
              r_load_ph <= 1'b1;
            end
          end
          S_START: begin
            cpu_s   <= 1'b0;
            r_tcnt  <= '0;
            r_state <= S_WAIT_LEAVE;
          end
          S_WAIT_LEAVE: begin
            if (!cpu_w) begin
              r_tcnt  <= '0;
              r_state <= S_WAIT_DONE;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_WAIT_DONE: begin
            // Capture here so result/flags are already valid in the cycle done is high.
            if (cpu_w) begin
              result  <= cpu_out;
              flags   <= {cpu_N, cpu_V, cpu_Z};
              done    <= 1'b1;
              r_state <= S_CAPTURE;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_CAPTURE: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ERR: begin
            r_state <= S_ERR;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: a cpu stub with per-instruction w timing and a
// transaction-level model that predicts every output from issue times and stub latencies.
`timescale 1ns/1ps

module tb_instr_feeder;

  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic [15:0] push_data = '0;
  logic        cpu_w = 1'b1;
  logic [15:0] cpu_out = '0;
  logic        cpu_N = 1'b0, cpu_V = 1'b0, cpu_Z = 1'b0;
  logic        full, empty, ovf, cpu_load, cpu_s, done, busy, timeout_err;
  logic [15:0] cpu_in, result;
  logic [2:0]  flags;

  instr_feeder #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .push(push), .push_data(push_data),
    .full(full), .empty(empty), .ovf(ovf),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s),
    .cpu_w(cpu_w), .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .result(result), .flags(flags), .done(done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // One queued instruction plus the stub latencies it will see: lat_l cycles of w=1 after s,
  // then lat_r cycles of w=0.
  typedef struct {
    logic [15:0] data;
    int          lat_l;
    int          lat_r;
  } entry_t;

  entry_t      mq[$];
  entry_t      sq[$];
  entry_t      cur;
  int          cyc = 0;
  bit          in_flight = 0, err_m = 0, ovf_m = 0;
  int          t_issue = -100, t_done = -1, t_err = -1;
  logic [15:0] cpu_in_m = '0, result_m = '0;
  logic [2:0]  flags_m = '0;
  int          lat_l_next = 0, lat_r_next = 1;

  int n_checks = 0, n_errors = 0;
  int n_done = 0, n_load = 0, load_c = 0, done_c = 0, last_lat = 0;
  logic prev_load = 1'b0;
  int leave_at = 0, back_at = 0;
  logic [15:0] stub_instr = '0;

  function automatic logic [15:0] f_res(input logic [15:0] x);
    return x ^ 16'hA5A5;
  endfunction

  function automatic logic [2:0] f_flg(input logic [15:0] x);
    return x[2:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: advances one cycle per rising edge.
  initial begin
    bit     was_full;
    entry_t e;
    forever begin
      @(posedge clk);
      if (!reset) begin
        mq.delete(); sq.delete();
        in_flight = 0; err_m = 0; ovf_m = 0;
        cpu_in_m = '0; result_m = '0; flags_m = '0;
        cyc++;
      end else begin
        was_full = (mq.size() == DEPTH);
        if (in_flight && cyc == t_done) begin
          void'(mq.pop_front());
          in_flight = 0;
        end
        if (push) begin
          if (was_full) ovf_m = 1;
          else begin
            e = '{push_data, lat_l_next, lat_r_next};
            mq.push_back(e);
            sq.push_back(e);
          end
        end
        cyc++;
        if (in_flight && cyc == t_err) begin
          err_m = 1; in_flight = 0; cpu_in_m = '0;
        end
        if (in_flight && cyc == t_issue + 1) cpu_in_m = cur.data;
        if (in_flight && cyc == t_done) begin
          result_m = f_res(cur.data);
          flags_m  = f_flg(cur.data);
        end
        if (!in_flight && !err_m && mq.size() > 0) begin
          cur = mq[0];
          t_issue = cyc;
          t_done = -1; t_err = -1;
          if (cur.lat_l >= TO)      t_err  = t_issue + 4 + TO;
          else if (cur.lat_r > TO)  t_err  = t_issue + 5 + cur.lat_l + TO;
          else                      t_done = t_issue + 5 + cur.lat_l + cur.lat_r;
          in_flight = 1;
        end
      end
    end
  end

  // cpu stub: reacts to the feeder's s pulse.
  initial begin
    entry_t p;
    forever begin
      @(negedge clk);
      if (!reset) begin
        leave_at = 0; back_at = 0;
      end else if (cpu_s === 1'b1 && sq.size() > 0) begin
        p = sq.pop_front();
        leave_at = cyc + 1 + p.lat_l;
        back_at  = leave_at + p.lat_r;
        stub_instr = cpu_in;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= leave_at && cyc < back_at) begin
        cpu_w = 1'b0;
        cpu_out = 16'($urandom);
        {cpu_N, cpu_V, cpu_Z} = 3'($urandom);
      end else begin
        cpu_w = 1'b1;
        cpu_out = f_res(stub_instr);
        {cpu_N, cpu_V, cpu_Z} = f_flg(stub_instr);
      end
    end
  end

  // Compare process: every cycle, mid-period.
  initial begin
    int cnt;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_cpu_in", 32'(cpu_in), 32'd0);
        check("rst_load_s", {30'd0, cpu_load, cpu_s}, 32'd0);
        check("rst_result", {13'd0, result, flags}, 32'd0);
        check("rst_done_busy_err", {29'd0, done, busy, timeout_err}, 32'd0);
      end else begin
        cnt = mq.size();
        check("full", 32'(full), 32'(cnt == DEPTH));
        check("empty", 32'(empty), 32'(cnt == 0));
        check("ovf", 32'(ovf), 32'(ovf_m));
        check("timeout_err", 32'(timeout_err), 32'(err_m));
        check("cpu_load", 32'(cpu_load),
              32'(in_flight && (cyc == t_issue + 1 || cyc == t_issue + 2)));
        check("cpu_s", 32'(cpu_s), 32'(in_flight && cyc == t_issue + 3));
        check("busy", 32'(busy), 32'(in_flight && cyc > t_issue));
        check("done", 32'(done), 32'(in_flight && cyc == t_done));
        check("cpu_in", 32'(cpu_in), 32'(cpu_in_m));
        check("result", 32'(result), 32'(result_m));
        check("flags", 32'(flags), 32'(flags_m));
      end
      if (cpu_load === 1'b1) n_load++;
      if (cpu_load === 1'b1 && prev_load !== 1'b1) load_c = cyc;
      prev_load = cpu_load;
      if (done === 1'b1) begin
        n_done++;
        done_c = cyc;
        last_lat = done_c - load_c + 2;
      end
    end
  end

  task automatic push_one(input logic [15:0] d, input int l, input int r);
    push = 1'b1; push_data = d; lat_l_next = l; lat_r_next = r;
    @(posedge clk); #1;
    push = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    push = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    int k;
    start = n_done;
    k = 0;
    while (n_done == start && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 32'(n_done != start), 32'd1);
  endtask

  initial begin
    int base, l, r, k;
    // 1: reset then idle
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    base = n_load;
    repeat (20) @(posedge clk);
    #1;
    check("t1_no_load", 32'(n_load - base), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);

    // 2: single MOV
    push_one(16'hD214, 0, 1);
    wait_done("t2_done_wait", 40);
    check("t2_result", 32'(result), 32'h77B1);
    check("t2_flags", 32'(flags), 32'd4);
    check("t2_latency", 32'(last_lat), 32'd7);

    // 3: three queued, w low for 3 cycles each
    base = n_done;
    push_one(16'h1111, 0, 3);
    push_one(16'h2222, 0, 3);
    push_one(16'h3333, 0, 3);
    for (int i = 0; i < 3; i++) wait_done("t3_done_wait", 40);
    check("t3_done_count", 32'(n_done - base), 32'd3);
    check("t3_latency", 32'(last_lat), 32'd9);
    check("t3_result", 32'(result), 32'(f_res(16'h3333)));
    check("t3_empty", 32'(empty), 32'd1);

    // 4: FIFO boundaries with a slow first instruction
    base = n_done;
    push_one(16'h4000, 0, TO - 1);
    for (int i = 1; i <= DEPTH; i++) push_one(16'h4000 + 16'(i), int'($urandom_range(0, 2)),
                                             int'($urandom_range(1, 3)));
    check("t4_full", 32'(full), 32'd1);
    check("t4_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) wait_done("t4_done_wait", 60);
    repeat (3) @(posedge clk);
    #1;
    check("t4_done_count", 32'(n_done - base), 32'(DEPTH));
    check("t4_empty", 32'(empty), 32'd1);

    // Random traffic, including the longest legal wait in each wait state
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 15));
      l = (k == 0) ? TO - 1 : int'($urandom_range(0, 3));
      r = (k == 1) ? TO : int'($urandom_range(1, 4));
      push = ($urandom_range(0, 2) == 0);
      push_data = 16'($urandom);
      lat_l_next = l; lat_r_next = r;
      @(posedge clk); #1;
    end
    push = 1'b0;
    k = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check("rand_drained", 32'(empty === 1'b1 && busy === 1'b0), 32'd1);

    // 5: timeout in WAIT_LEAVE, then in WAIT_DONE
    do_reset();
    push_one(16'h5555, TO + 3, 1);
    k = 0;
    while (timeout_err !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_err", 32'(timeout_err), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cpu_out", {15'd0, cpu_in, cpu_load}, 32'd0);
    push_one(16'h0001, 0, 1);
    push_one(16'h0002, 0, 1);
    repeat (30) @(posedge clk);
    #1;
    check("t5_err_sticky", 32'(timeout_err), 32'd1);
    check("t5_push_kept", 32'(empty), 32'd0);
    do_reset();
    check("t5_err_cleared", 32'(timeout_err), 32'd0);
    push_one(16'h6666, 1, TO + 1);
    k = 0;
    while (timeout_err !== 1'b1 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("t5_err_wait_done", 32'(timeout_err), 32'd1);

    // 6: reset mid-instruction
    do_reset();
    push_one(16'h0F0F, 0, 10);
    k = 0;
    while (cpu_w !== 1'b0 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    base = n_done;
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    check("t6_no_done", 32'(n_done - base), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    push_one(16'h1234, 0, 1);
    wait_done("t6_done_wait", 40);
    check("t6_result", 32'(result), 32'hB791);
    check("t6_flags", 32'(flags), 32'd4);
    check("t6_latency", 32'(last_lat), 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
